// File: rtl/gps_accum_pkg.sv
// Shared widths, slot-state encoding and the epoch result bundle for the
// GPS integrate-and-dump path.
package gps_accum_pkg;

  localparam int SAMPLE_W_DEF = 8;
  localparam int ACC_W_DEF    = 24;
  localparam int CNT_W_DEF    = 14;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Fields are sized for the default build; narrower instances sign/zero-extend into them.
  typedef struct packed {
    logic signed [ACC_W_DEF-1:0] acc_i;
    logic signed [ACC_W_DEF-1:0] acc_q;
    logic [CNT_W_DEF-1:0]        cnt;
    logic                        sat;
  } epoch_result_t;

endpackage

// File: rtl/integrate_dump_sat_add.sv
// Signed saturating accumulate step: a_i + sign-extended b_i, clamped to the
// ACC_W range, with a flag raised whenever clamping happened.
module sat_add #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [IN_W-1:0]  b_i,
  input  logic                    en_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    sat_o
);

  localparam logic signed [ACC_W-1:0] MAX_C = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_C = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] wide_s;

  // One guard bit: overflow shows up as disagreement between the top two bits.
  always_comb begin
    wide_s = {a_i[ACC_W-1], a_i} + {{(ACC_W+1-IN_W){b_i[IN_W-1]}}, b_i};
    if (!en_i) begin
      sum_o = a_i;
      sat_o = 1'b0;
    end else if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
      sum_o = wide_s[ACC_W] ? MIN_C : MAX_C;
      sat_o = 1'b1;
    end else begin
      sum_o = wide_s[ACC_W-1:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/integrate_dump.sv
// Integrate-and-dump accumulator: sums I/Q samples over an epoch and offers
// the totals on dump through a one-entry valid/ready result slot.
module integrate_dump
  import gps_accum_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic signed [SAMPLE_W-1:0] sample_q,
  input  logic                       dump,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    acc_i_out,
  output logic signed [ACC_W-1:0]    acc_q_out,
  output logic [CNT_W-1:0]           cnt_out,
  output logic                       sat_out,
  output logic                       overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, sat_d;

  logic signed [ACC_W-1:0] sum_i_s, sum_q_s;
  logic                    sat_i_s, sat_q_s;

  slot_state_e   state_q;
  epoch_result_t res_q, tot_s;
  logic          out_valid_q, overrun_q;
  logic          unused_s;

  sat_add #(.IN_W(SAMPLE_W), .ACC_W(ACC_W)) u_add_i (
    .a_i   (acc_i_q),
    .b_i   (sample_i),
    .en_i  (sample_valid),
    .sum_o (sum_i_s),
    .sat_o (sat_i_s)
  );

  sat_add #(.IN_W(SAMPLE_W), .ACC_W(ACC_W)) u_add_q (
    .a_i   (acc_q_q),
    .b_i   (sample_q),
    .en_i  (sample_valid),
    .sum_o (sum_q_s),
    .sat_o (sat_q_s)
  );

  // Sample count holds at full scale instead of wrapping.
  always_comb begin
    if (sample_valid && (cnt_q != CNT_MAX_C)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    sat_d = sat_q | sat_i_s | sat_q_s;
  end

  // Epoch totals include a sample arriving in the dump cycle.
  always_comb begin
    tot_s       = '0;
    tot_s.acc_i = ACC_W_DEF'(sum_i_s);
    tot_s.acc_q = ACC_W_DEF'(sum_q_s);
    tot_s.cnt   = CNT_W_DEF'(cnt_d);
    tot_s.sat   = sat_d;
  end

  // Running accumulators; every dump, dropped or not, starts a fresh epoch.
  always_ff @(posedge clk_in) begin
    if (rst || dump) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      acc_i_q <= sum_i_s;
      acc_q_q <= sum_q_s;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Result slot FSM with registered valid, data and sticky overrun.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= SLOT_EMPTY;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (dump) begin
            res_q       <= tot_s;
            state_q     <= SLOT_FULL;
            out_valid_q <= 1'b1;
          end
        end
        SLOT_FULL: begin
          if (dump && out_ready) begin
            res_q <= tot_s;
          end else if (dump) begin
            overrun_q <= 1'b1;
          end else if (out_ready) begin
            state_q     <= SLOT_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= SLOT_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign acc_i_out = res_q.acc_i[ACC_W-1:0];
  assign acc_q_out = res_q.acc_q[ACC_W-1:0];
  assign cnt_out   = res_q.cnt[CNT_W-1:0];
  assign sat_out   = res_q.sat;
  // Narrower builds leave high bundle bits unread; fold them here.
  assign unused_s  = ^res_q;

endmodule

// File: tb/tb_integrate_dump.sv
// Directed bench for integrate_dump: a bench-side model pushes expected epochs
// onto a scoreboard queue at dump time and pops them at each handshake.
module tb_integrate_dump;

  logic clk_in = 1'b0;
  logic rst, sample_valid, dump, out_ready;
  logic signed [7:0] sample_i, sample_q;

  logic               out_valid, sat_out, overrun;
  logic signed [23:0] acc_i_out, acc_q_out;
  logic [13:0]        cnt_out;

  logic               out_valid12, sat_out12, overrun12;
  logic signed [11:0] acc_i_out12, acc_q_out12;
  logic [13:0]        cnt_out12;

  always #5 clk_in = ~clk_in;

  integrate_dump dut (
    .clk_in(clk_in), .rst(rst), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .dump(dump),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_i_out(acc_i_out), .acc_q_out(acc_q_out), .cnt_out(cnt_out),
    .sat_out(sat_out), .overrun(overrun)
  );

  integrate_dump #(.ACC_W(12)) dut12 (
    .clk_in(clk_in), .rst(rst), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .dump(dump),
    .out_valid(out_valid12), .out_ready(out_ready),
    .acc_i_out(acc_i_out12), .acc_q_out(acc_q_out12), .cnt_out(cnt_out12),
    .sat_out(sat_out12), .overrun(overrun12)
  );

  typedef struct {
    longint ai;
    longint aq;
    longint cnt;
    logic   sat;
  } res_t;

  res_t   sb_q[$];
  int     total = 0;
  int     bad = 0;
  longint m_ai, m_aq, m_cnt;
  logic   m_sat, m_ovr;

  function automatic longint clamp(input longint v, input int w, output logic s);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    s  = 1'b0;
    if (v > hi) begin
      s = 1'b1;
      return hi;
    end
    if (v < lo) begin
      s = 1'b1;
      return lo;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the slot against the scoreboard, advance the model.
  task automatic cycle(input bit v, input int si, input int sq, input bit d, input bit r);
    longint t_ai, t_aq, t_cnt;
    logic   t_sat, s1, s2;
    res_t   e;
    sample_valid = v;
    sample_i     = 8'(si);
    sample_q     = 8'(sq);
    dump         = d;
    out_ready    = r;
    chk("out_valid", out_valid, (sb_q.size() != 0));
    chk("overrun", overrun, m_ovr);
    if (sb_q.size() != 0) begin
      chk("acc_i", acc_i_out, sb_q[0].ai);
      chk("acc_q", acc_q_out, sb_q[0].aq);
      chk("cnt", cnt_out, sb_q[0].cnt);
      chk("sat", sat_out, sb_q[0].sat);
      if (r) void'(sb_q.pop_front());
    end
    t_ai = m_ai; t_aq = m_aq; t_cnt = m_cnt; t_sat = m_sat;
    if (v) begin
      t_ai  = clamp(m_ai + si, 24, s1);
      t_aq  = clamp(m_aq + sq, 24, s2);
      t_sat = m_sat | s1 | s2;
      t_cnt = (m_cnt == 16383) ? m_cnt : m_cnt + 1;
    end
    if (d) begin
      if (sb_q.size() == 0) begin
        e.ai = t_ai; e.aq = t_aq; e.cnt = t_cnt; e.sat = t_sat;
        sb_q.push_back(e);
      end else begin
        m_ovr = 1'b1;
      end
      m_ai = 0; m_aq = 0; m_cnt = 0; m_sat = 1'b0;
    end else begin
      m_ai = t_ai; m_aq = t_aq; m_cnt = t_cnt; m_sat = t_sat;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0; dump = 1'b0; out_ready = 1'b0;
    sample_i = '0; sample_q = '0;
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_ai = 0; m_aq = 0; m_cnt = 0; m_sat = 1'b0; m_ovr = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_acc_i", acc_i_out, 0);
    chk("rst_acc_q", acc_q_out, 0);
    chk("rst_cnt", cnt_out, 0);
    chk("rst_sat", sat_out, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; dump = 1'b0; out_ready = 1'b0;
    sample_i = '0; sample_q = '0;
    m_ai = 0; m_aq = 0; m_cnt = 0; m_sat = 1'b0; m_ovr = 1'b0;
    @(posedge clk_in);
    #1;
    do_reset();

    // 10 samples, dump with the 10th
    for (int k = 0; k < 9; k++) cycle(1'b1, 3, -2, 1'b0, 1'b1);
    cycle(1'b1, 3, -2, 1'b1, 1'b1);
    chk("t1_acc_i", acc_i_out, 30);
    chk("t1_acc_q", acc_q_out, -20);
    chk("t1_cnt", cnt_out, 10);
    chk("t1_sat", sat_out, 0);
    chk("t1_valid", out_valid, 1);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    chk("t1_valid_fall", out_valid, 0);

    // 12-bit saturation, then a clean epoch
    for (int k = 0; k < 39; k++) cycle(1'b1, 127, 0, 1'b0, 1'b1);
    cycle(1'b1, 127, 0, 1'b1, 1'b1);
    chk("t2_valid12", out_valid12, 1);
    chk("t2_acc_i12", acc_i_out12, 2047);
    chk("t2_sat12", sat_out12, 1);
    chk("t2_acc_i24", acc_i_out, 5080);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    cycle(1'b1, 1, 0, 1'b0, 1'b1);
    cycle(1'b1, 1, 0, 1'b1, 1'b1);
    chk("t2b_acc_i12", acc_i_out12, 2);
    chk("t2b_sat12", sat_out12, 0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);

    // Negative saturation on the 24-bit instance is out of reach; check Q sign instead
    do_reset();
    cycle(1'b1, -128, -128, 1'b0, 1'b0);
    cycle(1'b1, -128, 127, 1'b1, 1'b0);
    chk("t2c_acc_i", acc_i_out, -256);
    chk("t2c_acc_q", acc_q_out, -1);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);

    // Overrun: two dumps 5 cycles apart with out_ready low
    do_reset();
    cycle(1'b1, 2, 1, 1'b0, 1'b0);
    cycle(1'b1, 2, 1, 1'b0, 1'b0);
    cycle(1'b1, 2, 1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 9, 9, 1'b0, 1'b0);
    cycle(1'b1, 9, 9, 1'b1, 1'b0);
    chk("t3_overrun", overrun, 1);
    chk("t3_held_acc_i", acc_i_out, 6);
    chk("t3_held_cnt", cnt_out, 3);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    chk("t3_gone", out_valid, 0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);

    // Back-to-back: slot full, dump with out_ready
    do_reset();
    cycle(1'b1, -4, 0, 1'b1, 1'b0);
    cycle(1'b1, 7, 0, 1'b0, 1'b0);
    cycle(1'b1, 7, 0, 1'b0, 1'b0);
    cycle(1'b1, 7, 0, 1'b1, 1'b1);
    chk("t4_valid", out_valid, 1);
    chk("t4_acc_i", acc_i_out, 21);
    chk("t4_cnt", cnt_out, 3);
    chk("t4_overrun", overrun, 0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);

    // Dumps on consecutive cycles
    do_reset();
    cycle(1'b1, 5, 0, 1'b1, 1'b1);
    chk("t5a_acc_i", acc_i_out, 5);
    chk("t5a_cnt", cnt_out, 1);
    cycle(1'b1, 5, 0, 1'b1, 1'b1);
    chk("t5b_acc_i", acc_i_out, 5);
    chk("t5b_cnt", cnt_out, 1);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);

    // Empty epoch
    cycle(1'b0, 0, 0, 1'b1, 1'b1);
    chk("t6_valid", out_valid, 1);
    chk("t6_cnt", cnt_out, 0);
    chk("t6_acc_i", acc_i_out, 0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);

    // Count saturation
    for (int k = 0; k < 16399; k++) cycle(1'b1, 1, 0, 1'b0, 1'b1);
    cycle(1'b1, 1, 0, 1'b1, 1'b1);
    chk("t7_cnt_sat", cnt_out, 16383);
    chk("t7_acc_i", acc_i_out, 16400);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);

    // Reset mid-epoch with a held result
    do_reset();
    cycle(1'b1, 4, 4, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) cycle(1'b1, 6, 6, 1'b0, 1'b0);
    chk("t8_pre_valid", out_valid, 1);
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 1, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, 1'b1);
    chk("t8_cnt", cnt_out, 3);
    chk("t8_acc_i", acc_i_out, 3);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
